// File: rtl/rx_ctrl.sv
// UART receive sequencer: start detection, mid-bit shift strobes, stop check and host flags.
// Optional start-bit glitch rejection is enabled by defining RX_GLITCH_REJECT_EN.
module rx_ctrl #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic stop_bit,
    input  logic data_read,
    output logic shift_strobe,
    output logic load_buffer,
    output logic busy,
    output logic data_ready,
    output logic framing_error,
    output logic overrun_error
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_CHECK,
        RECEIVE,
        CHECK_STOP,
        LOAD
    } state_t;

    state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0] strb_q;
    logic       prev_q;
    logic       data_ready_q;
    logic       framing_error_q;
    logic       overrun_error_q;
    logic       start_edge;

    assign start_edge = (state_q == IDLE) && prev_q && !serial_in;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            strb_q          <= '0;
            prev_q          <= 1'b1;
            data_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            prev_q <= serial_in;
            cnt_q  <= cnt_q + 1'b1;

            // Host read clears; a LOAD in the same cycle overrides data_ready below.
            if (data_read) begin
                data_ready_q    <= 1'b0;
                overrun_error_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    strb_q <= '0;
                    if (start_edge) begin
                        state_q <= START_CHECK;
                    end
                end
                START_CHECK: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q  <= '0;
                        strb_q <= '0;
`ifdef RX_GLITCH_REJECT_EN
                        if (serial_in) begin
                            state_q <= IDLE;
                        end else begin
                            state_q         <= RECEIVE;
                            framing_error_q <= 1'b0;
                        end
`else
                        state_q         <= RECEIVE;
                        framing_error_q <= 1'b0;
`endif
                    end
                end
                RECEIVE: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q  <= '0;
                        strb_q <= strb_q + 4'd1;
                        // Ninth strobe captures the stop bit; leave on that edge.
                        if (strb_q == 4'd8) begin
                            state_q <= CHECK_STOP;
                            strb_q  <= '0;
                        end
                    end
                end
                CHECK_STOP: begin
                    cnt_q  <= '0;
                    strb_q <= '0;
                    if (stop_bit) begin
                        state_q <= LOAD;
                    end else begin
                        state_q         <= IDLE;
                        framing_error_q <= 1'b1;
                    end
                end
                LOAD: begin
                    cnt_q        <= '0;
                    strb_q       <= '0;
                    state_q      <= IDLE;
                    data_ready_q <= 1'b1;
                    if (data_ready_q && !data_read) begin
                        overrun_error_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    strb_q  <= '0;
                end
            endcase
        end
    end

    assign shift_strobe  = (state_q == RECEIVE) && (cnt_q == BIT_LAST);
    assign load_buffer   = (state_q == LOAD);
    assign busy          = (state_q != IDLE);
    assign data_ready    = data_ready_q;
    assign framing_error = framing_error_q;
    assign overrun_error = overrun_error_q;

endmodule

// File: tb/tb_rx_ctrl.sv
// Scoreboard bench for rx_ctrl: stimulus queues expected strobe/load events, a monitor pops them.
// Build with or without RX_GLITCH_REJECT_EN to match the DUT configuration.
module tb_rx_ctrl;

    logic clk = 1'b0;
    logic n_rst, serial_in, stop_bit, data_read;
    logic shift_strobe, load_buffer, busy, data_ready, framing_error, overrun_error;

    int cyc   = 0;
    int t0    = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] sr = '1;

    typedef struct {
        int         cyc;
        bit         is_load;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    rx_ctrl #(.CLKS_PER_BIT(10)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .stop_bit     (stop_bit),
        .data_read    (data_read),
        .shift_strobe (shift_strobe),
        .load_buffer  (load_buffer),
        .busy         (busy),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receive shift register model: LSB first, stop bit ends up in the top position.
    always @(posedge clk) if (shift_strobe) sr <= {serial_in, sr[8:1]};
    assign stop_bit = sr[8];

    always @(negedge clk) begin
        if (shift_strobe === 1'b1 || load_buffer === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event at cycle %0d (rel %0d): strobe=%b load=%b, expected none",
                         cyc, cyc - t0, shift_strobe, load_buffer);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.is_load != load_buffer ||
                    (load_buffer && sr[7:0] != mon_e.data)) begin
                    n_bad++;
                    $display("FAIL event: got strobe=%b load=%b data=%h at rel %0d, expected load=%b data=%h at rel %0d",
                             shift_strobe, load_buffer, sr[7:0], cyc - t0,
                             mon_e.is_load, mon_e.data, mon_e.cyc - t0);
                end else begin
                    $display("event %s at rel cycle %0d data=%h", load_buffer ? "load  " : "strobe",
                             cyc - t0, sr[7:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int k);
        @(negedge clk);
        while (cyc < t0 + k) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at rel cycle %0d: got %b, expected %b", name, cyc - t0, act, req);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_strobe"}, shift_strobe, 1'b0);
        chk({tag, "_load"}, load_buffer, 1'b0);
        chk({tag, "_ready"}, data_ready, 1'b0);
        chk({tag, "_ferr"}, framing_error, 1'b0);
        chk({tag, "_oerr"}, overrun_error, 1'b0);
    endtask

    task automatic push_frame(input int nstrobes, input bit load, input logic [7:0] d);
        for (int j = 0; j < nstrobes; j++) exp_q.push_back('{t0 + 15 + 10 * j, 1'b0, 8'h00});
        if (load) exp_q.push_back('{t0 + 97, 1'b1, d});
    endtask

    function automatic logic [99:0] frame_pat(input logic [7:0] d, input logic stop);
        logic [9:0]  bits;
        logic [99:0] p;
        bits = {stop, d, 1'b0};
        for (int k = 0; k < 100; k++) p[k] = bits[k / 10];
        return p;
    endfunction

    task automatic drive(input logic [99:0] p);
        for (int k = 0; k < 100; k++) begin
            serial_in = p[k];
            sync();
        end
        serial_in = 1'b1;
    endtask

    task automatic read_pulse(input string tag);
        data_read = 1'b1;
        sync();
        data_read = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_cleared"}, data_ready, 1'b0);
        chk({tag, "_oerr_cleared"}, overrun_error, 1'b0);
        sync();
    endtask

    logic [99:0] pat;

    initial begin
        n_rst     = 1'b0;
        serial_in = 1'b1;
        data_read = 1'b0;
        repeat (3) sync();
        @(negedge clk);
        chk_all_zero("reset");
        sync();
        n_rst = 1'b1;
        repeat (3) sync();

        // 1: good frame 0xA5
        t0 = cyc;
        push_frame(9, 1'b1, 8'hA5);
        fork
            drive(frame_pat(8'hA5, 1'b1));
            begin
                at(0);  chk("t1_busy_c0", busy, 1'b0);
                at(1);  chk("t1_busy_c1", busy, 1'b1);
                at(97); chk("t1_busy_c97", busy, 1'b1); chk("t1_ready_c97", data_ready, 1'b0);
                at(98); chk("t1_ready_c98", data_ready, 1'b1); chk("t1_ferr", framing_error, 1'b0);
                chk("t1_busy_c98", busy, 1'b0);
            end
        join
        $display("frame 1 (0xA5 good) done");
        read_pulse("t1");

        // 2: bad stop bit, then a good frame clears framing_error at RECEIVE entry
        repeat (2) sync();
        t0 = cyc;
        push_frame(9, 1'b0, 8'h00);
        fork
            drive(frame_pat(8'h3C, 1'b0));
            begin
                at(96); chk("t2_ferr_c96", framing_error, 1'b0); chk("t2_busy_c96", busy, 1'b1);
                at(97); chk("t2_ferr_c97", framing_error, 1'b1); chk("t2_busy_c97", busy, 1'b0);
                chk("t2_ready_c97", data_ready, 1'b0);
            end
        join
        $display("frame 2 (0x3C bad stop) done");
        repeat (2) sync();
        t0 = cyc;
        push_frame(9, 1'b1, 8'h5A);
        fork
            drive(frame_pat(8'h5A, 1'b1));
            begin
                at(5);  chk("t2b_ferr_c5", framing_error, 1'b1);
                at(6);  chk("t2b_ferr_c6", framing_error, 1'b0);
                at(98); chk("t2b_ready", data_ready, 1'b1);
            end
        join
        $display("frame 3 (0x5A good) done");

        // 3: second unread frame overruns
        repeat (2) sync();
        t0 = cyc;
        push_frame(9, 1'b1, 8'hC3);
        fork
            drive(frame_pat(8'hC3, 1'b1));
            begin
                at(97); chk("t3_oerr_c97", overrun_error, 1'b0);
                at(98); chk("t3_oerr_c98", overrun_error, 1'b1); chk("t3_ready", data_ready, 1'b1);
            end
        join
        $display("frame 4 (0xC3 overrun) done");
        read_pulse("t3");

        // 4: data_read coincident with LOAD while data_ready is set
        repeat (2) sync();
        t0 = cyc;
        push_frame(9, 1'b1, 8'h0F);
        fork
            drive(frame_pat(8'h0F, 1'b1));
            begin
                at(98); chk("t4a_ready", data_ready, 1'b1); chk("t4a_oerr", overrun_error, 1'b0);
            end
        join
        $display("frame 5 (0x0F good) done");
        repeat (2) sync();
        t0 = cyc;
        push_frame(9, 1'b1, 8'hF0);
        fork
            drive(frame_pat(8'hF0, 1'b1));
            begin
                at(96); chk("t4_ready_c96", data_ready, 1'b1);
                sync(); data_read = 1'b1;
                sync(); data_read = 1'b0;
                at(98); chk("t4_ready_c98", data_ready, 1'b1); chk("t4_oerr_c98", overrun_error, 1'b0);
            end
        join
        $display("frame 6 (0xF0 read during load) done");

        // 5: two-cycle low glitch
        repeat (2) sync();
        t0 = cyc;
        pat = '1;
        pat[1:0] = 2'b00;
`ifdef RX_GLITCH_REJECT_EN
        fork
            drive(pat);
            begin
                at(5);  chk("t5_busy_c5", busy, 1'b1);
                at(6);  chk("t5_busy_c6", busy, 1'b0);
                at(99); chk("t5_ready", data_ready, 1'b1); chk("t5_ferr", framing_error, 1'b0);
                chk("t5_oerr", overrun_error, 1'b0);
            end
        join
`else
        // Later low period lands on the stop-bit sample of the falsely started frame.
        pat[99:90] = '0;
        push_frame(9, 1'b0, 8'h00);
        fork
            drive(pat);
            begin
                at(6);  chk("t5_busy_c6", busy, 1'b1);
                at(96); chk("t5_ferr_c96", framing_error, 1'b0);
                at(97); chk("t5_ferr_c97", framing_error, 1'b1); chk("t5_ready", data_ready, 1'b1);
            end
        join
`endif
        $display("glitch test done");

        // 6: reset after the 4th strobe aborts the frame
        repeat (2) sync();
        t0 = cyc;
        pat = frame_pat(8'hA5, 1'b1);
        pat[99:46] = '1;
        push_frame(4, 1'b0, 8'h00);
        fork
            drive(pat);
            begin
                at(45); chk("t6_busy_c45", busy, 1'b1);
                sync(); n_rst = 1'b0;
                sync(); n_rst = 1'b1;
                at(47); chk_all_zero("t6_after_reset");
            end
        join
        $display("aborted frame done");
        repeat (2) sync();
        t0 = cyc;
        push_frame(9, 1'b1, 8'h81);
        fork
            drive(frame_pat(8'h81, 1'b1));
            begin
                at(98); chk("t6_ready", data_ready, 1'b1); chk("t6_ferr", framing_error, 1'b0);
                chk("t6_oerr", overrun_error, 1'b0);
            end
        join
        $display("frame 7 (0x81 good) done");

        repeat (5) sync();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: got %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
